// File: rtl/custom_axi_ip_pkg.sv
// custom_axi_ip_pkg: shared compute-stage status type and result FIFO constants
package custom_axi_ip_pkg;
  typedef enum logic [1:0] {IDLE, BUSY, DONE, ERROR} status_e;
  localparam int RESULT_ERR_CNT_W = 8;
endpackage

// File: rtl/custom_axi_ip_result_fifo_mem.sv
// custom_axi_ip_result_fifo_mem: unreset storage, synchronous write, asynchronous read
module custom_axi_ip_result_fifo_mem #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 8,
  parameter int AW         = $clog2(DEPTH)
) (
  input  logic                  clk_i,
  input  logic                  we,
  input  logic [AW-1:0]         waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [AW-1:0]         raddr,
  output logic [DATA_WIDTH-1:0] rdata
);
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  always_ff @(posedge clk_i) if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/custom_axi_ip_result_fifo.sv
// custom_axi_ip_result_fifo: result capture FIFO with overflow/error tracking; irq enabled by CUSTOM_AXI_IP_RESULT_FIFO_IRQ_EN
module custom_axi_ip_result_fifo
  import custom_axi_ip_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int DEPTH         = 8,
  parameter int IRQ_THRESHOLD = 4
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        wen_in,
  input  logic [DATA_WIDTH-1:0]       data_in,
  input  status_e                     status_in,
  input  logic                        rd_req_i,
  input  logic                        clr_overflow_i,
  output logic [DATA_WIDTH-1:0]       rd_data_o,
  output logic                        rd_valid_o,
  output logic [$clog2(DEPTH):0]      level_o,
  output logic                        empty_o,
  output logic                        full_o,
  output logic                        overflow_o,
  output logic [RESULT_ERR_CNT_W-1:0] err_cnt_o,
  output logic                        irq_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [DATA_WIDTH-1:0] rd_word;
  logic push, pop, drop;
  assign empty_o = level_o == '0;
  assign full_o  = level_o == LW'(DEPTH);
  // a pop in the same cycle frees the slot, so a push into a full FIFO is still taken
  assign push = wen_in && (!full_o || rd_req_i);
  assign pop  = rd_req_i && !empty_o;
  assign drop = wen_in && full_o && !rd_req_i;
  custom_axi_ip_result_fifo_mem #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(DEPTH)) u_mem (
    .clk_i (clk_i),
    .we    (push),
    .waddr (wr_ptr),
    .wdata (data_in),
    .raddr (rd_ptr),
    .rdata (rd_word)
  );
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      level_o    <= '0;
      rd_data_o  <= '0;
      rd_valid_o <= 1'b0;
      overflow_o <= 1'b0;
      err_cnt_o  <= '0;
    end else begin
      wr_ptr     <= wr_ptr + AW'(push);
      rd_ptr     <= rd_ptr + AW'(pop);
      level_o    <= level_o + LW'(push) - LW'(pop);
      rd_valid_o <= pop;
      if (pop) rd_data_o <= rd_word;
      overflow_o <= drop || (overflow_o && !clr_overflow_i);
      if (status_in == ERROR && err_cnt_o != '1) err_cnt_o <= err_cnt_o + 1'b1;
    end
  end
`ifdef CUSTOM_AXI_IP_RESULT_FIFO_IRQ_EN
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) irq_o <= 1'b0;
    else       irq_o <= (level_o >= LW'(IRQ_THRESHOLD)) || overflow_o;
  end
`else
  assign irq_o = 1'(IRQ_THRESHOLD) & 1'b0;
`endif
endmodule

// File: tb/tb_custom_axi_ip_result_fifo.sv
// tb_custom_axi_ip_result_fifo: randomized self-checking bench against a queue-based reference model
module tb_custom_axi_ip_result_fifo;
  import custom_axi_ip_pkg::*;
  localparam int DW = 32, DEPTH = 8, THR = 4;
  logic clk_i = 0, rst_i = 1;
  logic wen_in = 0, rd_req_i = 0, clr_overflow_i = 0;
  logic [DW-1:0] data_in = 0;
  status_e status_in = IDLE;
  logic [DW-1:0] rd_data_o;
  logic rd_valid_o, empty_o, full_o, overflow_o, irq_o;
  logic [3:0] level_o;
  logic [7:0] err_cnt_o;
  int n_chk = 0, n_pass = 0;
  logic [DW-1:0] q[$];
  logic [DW-1:0] m_data;
  bit m_valid, m_ovf, m_irq;
  int m_err;

  custom_axi_ip_result_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .IRQ_THRESHOLD(THR)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .wen_in(wen_in), .data_in(data_in), .status_in(status_in),
    .rd_req_i(rd_req_i), .clr_overflow_i(clr_overflow_i), .rd_data_o(rd_data_o),
    .rd_valid_o(rd_valid_o), .level_o(level_o), .empty_o(empty_o), .full_o(full_o),
    .overflow_o(overflow_o), .err_cnt_o(err_cnt_o), .irq_o(irq_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic model_reset();
    q.delete();
    m_data = 0; m_valid = 0; m_ovf = 0; m_irq = 0; m_err = 0;
  endtask

  task automatic step(input bit w, input logic [DW-1:0] d, input bit r, input bit c, input status_e s);
    bit full_now, irq_next;
    wen_in = w; data_in = d; rd_req_i = r; clr_overflow_i = c; status_in = s;
`ifdef CUSTOM_AXI_IP_RESULT_FIFO_IRQ_EN
    irq_next = (q.size() >= THR) || m_ovf;
`else
    irq_next = 0;
`endif
    full_now = q.size() == DEPTH;
    @(posedge clk_i); #1;
    m_valid = r && q.size() > 0;
    if (m_valid) m_data = q.pop_front();
    if (w && (!full_now || r)) q.push_back(d);
    if (w && full_now && !r) m_ovf = 1;
    else if (c) m_ovf = 0;
    if (s == ERROR && m_err < 255) m_err++;
    m_irq = irq_next;
    wen_in = 0; rd_req_i = 0; clr_overflow_i = 0; status_in = IDLE;
  endtask

  task automatic test_reset();
    rst_i = 1;
    repeat (3) @(posedge clk_i);
    #1 rst_i = 0;
    model_reset();
    n_chk++; if (empty_o !== 1'b1) $display("FAIL reset_empty: got %0b expected 1", empty_o); else n_pass++;
    n_chk++; if (level_o !== 4'd0) $display("FAIL reset_level: got %0d expected 0", level_o); else n_pass++;
    n_chk++; if (full_o !== 1'b0 || overflow_o !== 1'b0 || rd_valid_o !== 1'b0 || irq_o !== 1'b0)
      $display("FAIL reset_flags: got full=%0b ovf=%0b valid=%0b irq=%0b expected all 0", full_o, overflow_o, rd_valid_o, irq_o);
    else n_pass++;
    n_chk++; if (rd_data_o !== '0 || err_cnt_o !== 8'd0) $display("FAIL reset_data: got data=%0h err=%0d expected 0/0", rd_data_o, err_cnt_o); else n_pass++;
  endtask

  task automatic test_single();
    step(1, 32'h5, 0, 0, IDLE);
    n_chk++; if (level_o !== 4'd1 || empty_o !== 1'b0) $display("FAIL single_push: got level=%0d empty=%0b expected 1/0", level_o, empty_o); else n_pass++;
    step(0, 0, 1, 0, IDLE);
    n_chk++; if (rd_data_o !== 32'h5 || rd_valid_o !== 1'b1) $display("FAIL single_pop: got data=%0h valid=%0b expected 5/1", rd_data_o, rd_valid_o); else n_pass++;
    n_chk++; if (level_o !== 4'd0 || empty_o !== 1'b1) $display("FAIL single_level: got level=%0d empty=%0b expected 0/1", level_o, empty_o); else n_pass++;
    step(0, 0, 0, 0, IDLE);
    n_chk++; if (rd_valid_o !== 1'b0 || rd_data_o !== 32'h5) $display("FAIL single_pulse: got valid=%0b data=%0h expected 0/5", rd_valid_o, rd_data_o); else n_pass++;
  endtask

  task automatic test_fill_overflow();
    for (int i = 0; i < DEPTH; i++) step(1, 32'h10 + i, 0, 0, IDLE);
    n_chk++; if (full_o !== 1'b1 || level_o !== 4'd8 || overflow_o !== 1'b0)
      $display("FAIL fill_full: got full=%0b level=%0d ovf=%0b expected 1/8/0", full_o, level_o, overflow_o);
    else n_pass++;
    step(1, 32'h18, 0, 0, IDLE);
    n_chk++; if (overflow_o !== 1'b1 || level_o !== 4'd8) $display("FAIL overflow_set: got ovf=%0b level=%0d expected 1/8", overflow_o, level_o); else n_pass++;
    step(1, 32'h19, 0, 1, IDLE);
    n_chk++; if (overflow_o !== 1'b1) $display("FAIL overflow_set_wins: got %0b expected 1", overflow_o); else n_pass++;
    step(0, 0, 0, 1, IDLE);
    n_chk++; if (overflow_o !== 1'b0) $display("FAIL overflow_clear: got %0b expected 0", overflow_o); else n_pass++;
  endtask

  task automatic test_full_push_pop();
    step(1, 32'hAA, 1, 0, IDLE);
    n_chk++; if (rd_data_o !== 32'h10 || rd_valid_o !== 1'b1 || overflow_o !== 1'b0 || level_o !== 4'd8)
      $display("FAIL full_push_pop: got data=%0h valid=%0b ovf=%0b level=%0d expected 10/1/0/8", rd_data_o, rd_valid_o, overflow_o, level_o);
    else n_pass++;
    for (int i = 0; i < DEPTH; i++) begin
      step(0, 0, 1, 0, IDLE);
      n_chk++; if (rd_data_o !== m_data || rd_valid_o !== 1'b1) $display("FAIL drain_%0d: got %0h expected %0h", i, rd_data_o, m_data); else n_pass++;
    end
    n_chk++; if (rd_data_o !== 32'hAA || empty_o !== 1'b1) $display("FAIL drain_last: got data=%0h empty=%0b expected aa/1", rd_data_o, empty_o); else n_pass++;
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 3; i++) step(1, $urandom, 0, 0, IDLE);
    for (int i = 0; i < 20; i++) begin
      step(1, $urandom, 1, 0, IDLE);
      n_chk++; if (rd_data_o !== m_data || level_o !== 4'd3) $display("FAIL wrap_%0d: got data=%0h level=%0d expected %0h/3", i, rd_data_o, level_o, m_data); else n_pass++;
    end
    for (int i = 0; i < 3; i++) step(0, 0, 1, 0, IDLE);
    n_chk++; if (rd_data_o !== m_data || empty_o !== 1'b1) $display("FAIL wrap_drain: got %0h expected %0h", rd_data_o, m_data); else n_pass++;
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      step($urandom_range(0, 2) != 0, $urandom, $urandom_range(0, 2) == 0, $urandom_range(0, 9) == 0, status_e'($urandom_range(0, 3)));
      n_chk++; if (rd_valid_o !== m_valid || (m_valid && rd_data_o !== m_data))
        $display("FAIL rand_read_%0d: got valid=%0b data=%0h expected %0b/%0h", i, rd_valid_o, rd_data_o, m_valid, m_data);
      else n_pass++;
      n_chk++; if (level_o !== 4'(q.size()) || empty_o !== (q.size() == 0) || full_o !== (q.size() == DEPTH))
        $display("FAIL rand_level_%0d: got level=%0d expected %0d", i, level_o, q.size());
      else n_pass++;
      n_chk++; if (overflow_o !== m_ovf || err_cnt_o !== 8'(m_err) || irq_o !== m_irq)
        $display("FAIL rand_flags_%0d: got ovf=%0b err=%0d irq=%0b expected %0b/%0d/%0b", i, overflow_o, err_cnt_o, irq_o, m_ovf, m_err, m_irq);
      else n_pass++;
    end
  endtask

  task automatic test_mid_reset();
    for (int i = 0; i < 5; i++) step(1, $urandom, 0, 0, ERROR);
    rst_i = 1; #2;
    n_chk++; if (level_o !== 4'd0 || empty_o !== 1'b1 || err_cnt_o !== 8'd0 || overflow_o !== 1'b0)
      $display("FAIL mid_reset: got level=%0d empty=%0b err=%0d ovf=%0b expected 0/1/0/0", level_o, empty_o, err_cnt_o, overflow_o);
    else n_pass++;
    @(posedge clk_i); #1 rst_i = 0;
    model_reset();
  endtask

  task automatic test_empty_pop_err();
    step(1, 32'h77, 0, 0, IDLE);
    step(0, 0, 1, 0, IDLE);
    step(0, 0, 1, 0, IDLE);
    n_chk++; if (rd_valid_o !== 1'b0 || rd_data_o !== 32'h77 || level_o !== 4'd0)
      $display("FAIL empty_pop: got valid=%0b data=%0h level=%0d expected 0/77/0", rd_valid_o, rd_data_o, level_o);
    else n_pass++;
    step(1, 32'h33, 1, 0, IDLE);
    n_chk++; if (rd_valid_o !== 1'b0 || level_o !== 4'd1) $display("FAIL empty_push_pop: got valid=%0b level=%0d expected 0/1", rd_valid_o, level_o); else n_pass++;
    step(0, 0, 1, 0, IDLE);
    for (int i = 0; i < 300; i++) begin
      step(0, 0, 0, 0, ERROR);
      if (i == 253) begin
        n_chk++; if (err_cnt_o !== 8'd254) $display("FAIL err_count: got %0d expected 254", err_cnt_o); else n_pass++;
      end
    end
    n_chk++; if (err_cnt_o !== 8'd255 || m_err != 255) $display("FAIL err_saturate: got %0d expected 255", err_cnt_o); else n_pass++;
  endtask

  task automatic test_irq();
    for (int i = 0; i < THR; i++) step(1, $urandom, 0, 0, IDLE);
    n_chk++; if (level_o !== 4'(THR)) $display("FAIL irq_level: got %0d expected %0d", level_o, THR); else n_pass++;
    step(0, 0, 0, 0, IDLE);
`ifdef CUSTOM_AXI_IP_RESULT_FIFO_IRQ_EN
    n_chk++; if (irq_o !== 1'b1) $display("FAIL irq_assert: got %0b expected 1", irq_o); else n_pass++;
`else
    n_chk++; if (irq_o !== 1'b0) $display("FAIL irq_disabled: got %0b expected 0", irq_o); else n_pass++;
`endif
    step(0, 0, 1, 0, IDLE);
    step(0, 0, 0, 0, IDLE);
    n_chk++; if (irq_o !== 1'b0 || irq_o !== m_irq) $display("FAIL irq_deassert: got %0b expected 0", irq_o); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill_overflow();
    test_full_push_pop();
    test_wrap();
    test_random();
    test_mid_reset();
    test_empty_pop_err();
    test_irq();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/custom_axi_ip_result_fifo.md
# custom_axi_ip_result_fifo

Result capture buffer directly downstream of the custom AXI IP compute stage. It collects each completed result from that stage's write strobe into a small FIFO, so software can drain results through the register read path without losing back-to-back completions. It also tracks overflow and error occurrences, and can raise a level-based interrupt.

## Interface
Parameters:
- DATA_WIDTH, 32, result word width
- DEPTH, 8, FIFO entries; power of two, ≥ 2
- IRQ_THRESHOLD, 4, fill level at which irq_o asserts; range 1..DEPTH

Ports (one clock; reset is asynchronous and active-high):
- clk_i  input  1  clock
- rst_i  input  1  asynchronous, active-high reset
- wen_in  input  1  result write strobe from compute stage (single-cycle pulse)
- data_in  input  DATA_WIDTH  result word, valid when wen_in=1
- status_in  input  status_e  compute stage status
- rd_req_i  input  1  pop request from register read side
- clr_overflow_i  input  1  clears overflow_o
- rd_data_o  output  DATA_WIDTH  popped word
- rd_valid_o  output  1  one-cycle pulse, rd_data_o valid
- level_o  output  $clog2(DEPTH)+1  current occupancy
- empty_o  output  1  level_o == 0
- full_o  output  1  level_o == DEPTH
- overflow_o  output  1  sticky: a write was dropped
- err_cnt_o  output  8  saturating count of ERROR status cycles
- irq_o  output  1  interrupt request

## Operation
- **Push:** on wen_in=1 and not full, store data_in at wr_ptr, then advance wr_ptr.
- **Push when full:** drop the word and set overflow_o. Exception: if rd_req_i=1 in the same cycle, the push is accepted.
- **Pop:** on rd_req_i=1 and not empty, register mem[rd_ptr] into rd_data_o, pulse rd_valid_o, then advance rd_ptr.
- **Pop when empty:** ignored. rd_valid_o stays 0 and rd_data_o holds its value. A simultaneous push into an empty FIFO is accepted, but there is no bypass, so the word becomes readable the next cycle.
- **Simultaneous push and pop:** level_o is unchanged.
- **Pointers:** $clog2(DEPTH) bits wide and wrap naturally. level_o is a separate counter, incremented and decremented per accepted push and pop.
- **Overflow flag:**
  - clr_overflow_i clears overflow_o.
  - If a clear and a new drop occur in the same cycle, the set wins (overflow_o=1).
- **Error counter:**
  - err_cnt_o increments on every cycle where status_in == ERROR.
  - It saturates at 255 and is cleared only by reset.
- **Data rules:** stored data is never modified. No arithmetic is applied to the payload.

## Timing
- Reset values: rd_data_o=0, rd_valid_o=0, level_o=0, empty_o=1, full_o=0, overflow_o=0, err_cnt_o=0, irq_o=0. Pointers reset to 0.
- All outputs are registered and update on the clk_i rising edge following the causing input.
- Push-to-readable latency is 1 cycle: a word written at edge N can be popped by rd_req_i sampled at edge N+1.
- Pop latency is 1 cycle: rd_req_i sampled at edge N gives rd_data_o and rd_valid_o valid after edge N.
- Back-to-back pushes and pops are supported every cycle. Full throughput is one word per cycle in each direction.
- Asserting rst_i mid-operation discards all contents immediately. Memory contents need not be cleared; pointers and flags must be.

## Configuration
- Macro: CUSTOM_AXI_IP_RESULT_FIFO_IRQ_EN
- **Defined:** irq_o is a registered level equal to (level_o ≥ IRQ_THRESHOLD) OR overflow_o. It deasserts the cycle after the condition clears.
- **Undefined:** irq_o is tied to 0, the threshold compare logic is omitted, and IRQ_THRESHOLD is unused.

## Structure
- custom_axi_ip_pkg holds status_e (IDLE, BUSY, DONE, ERROR, unchanged) and the new constant RESULT_ERR_CNT_W = 8.
- One sub-module, custom_axi_ip_result_fifo_mem: DEPTH × DATA_WIDTH storage with a synchronous write port and an asynchronous read port. Its contents are not reset.
- The top level holds the pointers, level counter, flags, error counter and irq logic.

## Test plan
- **Reset and single word:** apply rst_i, then push 0x0000_0005 and pop it. Expect empty_o=1 after reset; after the push, level_o=1 and empty_o=0; after the pop, rd_data_o=0x0000_0005, rd_valid_o pulses, level_o=0.
- **Fill and overflow:** push 0x10..0x17 (DEPTH=8), then push 0x18. Expect full_o=1, 0x18 dropped, overflow_o=1. Draining returns 0x10..0x17 in order. clr_overflow_i then clears overflow_o.
- **Full with simultaneous push and pop:** with the FIFO full, assert wen_in with 0xAA and rd_req_i together. Expect rd_data_o=0x10, no overflow, level_o stays 8, and 0xAA is read last.
- **Wrap-around:** run 20 push/pop pairs with an interleaved occupancy of 3. Expect output order to match input order across the pointer wrap.
- **Empty pop and error count:** pop while empty, and hold status_in=ERROR for 300 cycles. Expect rd_valid_o=0 on the empty pop and err_cnt_o=255 (saturated).
- **IRQ (macro defined):** push 4 words. Expect irq_o=1 when level_o reaches 4 and irq_o=0 after one pop. With the macro undefined, irq_o stays 0 throughout.
